// File: rtl/alu_result_fifo.sv
// Tagged result buffer behind the 16-bit ALU: derives status flags at push time
// and queues {result, op, flags} in a circular FIFO with valid/ready on both sides.
module alu_result_fifo #(
   parameter int DEPTH = 4,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [3:0]    in_op,
   input  logic [16:0]   in_y,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [16:0]   out_y,
   output logic [3:0]    out_op,
   output logic          out_z,
   output logic          out_c,
   output logic          out_n,
   output logic          out_ill,
   output logic [AW:0]   count,
   output logic          ovf
);

   typedef struct packed {
      logic [16:0] y;
      logic [3:0]  op;
      logic        z;
      logic        c;
      logic        n;
      logic        ill;
   } entry_t;

   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   // Carry is only meaningful for the add select; zero ignores the carry-out bit.
   function automatic entry_t make_entry(input logic [3:0] op, input logic [16:0] y);
      entry_t e;
      e.y   = y;
      e.op  = op;
      e.z   = (y[15:0] == 16'h0000);
      e.c   = (op == 4'd2) ? y[16] : 1'b0;
      e.n   = y[15];
      e.ill = (op > 4'd3);
      return e;
   endfunction

   entry_t          mem_q [DEPTH];
   entry_t          mem_d [DEPTH];
   logic [AW-1:0]   wp_q, wp_d;
   logic [AW-1:0]   rp_q, rp_d;
   logic [AW:0]     count_q, count_d;
   logic            ovf_q, ovf_d;
   logic            push_s, pop_s;
   entry_t          head_s;

   // Handshake decode and next-state for storage, pointers, occupancy and overflow.
   always_comb begin
      in_ready  = (count_q != FULL);
      out_valid = (count_q != {(AW+1){1'b0}});
      push_s    = in_valid && in_ready;
      pop_s     = out_valid && out_ready;
      mem_d     = mem_q;
      wp_d      = wp_q;
      rp_d      = rp_q;
      count_d   = count_q;

      if (push_s) begin
         mem_d[wp_q] = make_entry(in_op, in_y);
         wp_d        = wp_q + AW'(1);
      end else begin
         wp_d        = wp_q;
      end

      if (pop_s) begin
         rp_d = rp_q + AW'(1);
      end else begin
         rp_d = rp_q;
      end

      case ({push_s, pop_s})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase

      ovf_d = ovf_q | (in_valid & (count_q == FULL));
   end

   // Head presentation; everything reads as zero while the FIFO is empty.
   always_comb begin
      head_s = mem_q[rp_q];
      if (!out_valid) begin
         head_s = entry_t'(25'd0);
      end else begin
         head_s = mem_q[rp_q];
      end
      out_y   = head_s.y;
      out_op  = head_s.op;
      out_z   = head_s.z;
      out_c   = head_s.c;
      out_n   = head_s.n;
      out_ill = head_s.ill;
      count   = count_q;
      ovf     = ovf_q;
   end

   // Control state with synchronous reset; held entries are discarded on reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         wp_q    <= {AW{1'b0}};
         rp_q    <= {AW{1'b0}};
         count_q <= {(AW+1){1'b0}};
         ovf_q   <= 1'b0;
      end else begin
         wp_q    <= wp_d;
         rp_q    <= rp_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
      end
   end

   // Entry storage needs no reset: unoccupied slots are never presented.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: tb/tb_alu_result_fifo.sv
// Self-checking bench for alu_result_fifo (DEPTH = 4): directed vector table,
// hand-written wrap-around sequence and a randomized run against a queue model.
module tb_alu_result_fifo;

   logic        clk = 1'b0;
   logic        rst, in_valid, in_ready, out_valid, out_ready;
   logic [3:0]  in_op, out_op;
   logic [16:0] in_y, out_y;
   logic        out_z, out_c, out_n, out_ill, ovf;
   logic [2:0]  count;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   alu_result_fifo #(.DEPTH(4)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_y(in_y),
      .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y), .out_op(out_op),
      .out_z(out_z), .out_c(out_c), .out_n(out_n), .out_ill(out_ill),
      .count(count), .ovf(ovf)
   );

   typedef struct {
      logic        rst;
      logic        iv;
      logic [3:0]  op;
      logic [16:0] y;
      logic        ordy;
      logic        ev;
      logic [16:0] ey;
      logic [3:0]  eop;
      logic [3:0]  ef;      // {z, c, n, ill}
      logic [2:0]  ecnt;
      logic        erdy;
      logic        eovf;
   } vec_t;

   typedef struct {
      logic [16:0] y;
      logic [3:0]  op;
   } ent_t;

   vec_t vt[$];
   ent_t q[$];
   bit   movf;

   function automatic vec_t mk(input logic r, input logic iv, input logic [3:0] op,
                               input logic [16:0] y, input logic ordy, input logic ev,
                               input logic [16:0] ey, input logic [3:0] eop,
                               input logic [3:0] ef, input logic [2:0] ecnt,
                               input logic erdy, input logic eovf);
      vec_t v;
      v.rst = r; v.iv = iv; v.op = op; v.y = y; v.ordy = ordy;
      v.ev = ev; v.ey = ey; v.eop = eop; v.ef = ef; v.ecnt = ecnt;
      v.erdy = erdy; v.eovf = eovf;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_all(input string tag, input logic ev, input logic [16:0] ey,
                            input logic [3:0] eop, input logic [3:0] ef,
                            input logic [2:0] ecnt, input logic erdy, input logic eovf);
      check({tag, ".out_valid"}, 32'(out_valid), 32'(ev));
      check({tag, ".out_y"},     32'(out_y),     32'(ey));
      check({tag, ".out_op"},    32'(out_op),    32'(eop));
      check({tag, ".flags"},     32'({out_z, out_c, out_n, out_ill}), 32'(ef));
      check({tag, ".count"},     32'(count),     32'(ecnt));
      check({tag, ".in_ready"},  32'(in_ready),  32'(erdy));
      check({tag, ".ovf"},       32'(ovf),       32'(eovf));
   endtask

   // Drive one cycle of inputs on the falling edge, let the rising edge take them,
   // and return at the next falling edge where outputs are sampled.
   task automatic cycle(input logic r, input logic iv, input logic [3:0] op,
                        input logic [16:0] y, input logic ordy);
      rst = r; in_valid = iv; in_op = op; in_y = y; out_ready = ordy;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic model_expect(input string tag);
      logic        ev;
      logic [16:0] ey;
      logic [3:0]  eop;
      logic [3:0]  ef;
      ev  = (q.size() != 0);
      ey  = ev ? q[0].y  : 17'h0;
      eop = ev ? q[0].op : 4'h0;
      ef  = 4'h0;
      if (ev) begin
         ef[3] = (ey[15:0] == 16'h0);
         ef[2] = (eop == 4'd2) && ey[16];
         ef[1] = ey[15];
         ef[0] = (eop > 4'd3);
      end
      check_all(tag, ev, ey, eop, ef, 3'(q.size()), q.size() != 4, movf);
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_op = 4'h0; in_y = 17'h0; out_ready = 1'b0;

      //        rst   iv    op     y          ordy  ev    ey         eop    {z,c,n,ill} cnt   rdy   ovf
      vt.push_back(mk(1'b1,1'b0,4'd0,17'h00000,1'b0,1'b0,17'h00000,4'd0,4'b0000,3'd0,1'b1,1'b0));
      vt.push_back(mk(1'b0,1'b1,4'd2,17'h10000,1'b0,1'b1,17'h10000,4'd2,4'b1100,3'd1,1'b1,1'b0));
      vt.push_back(mk(1'b0,1'b0,4'd0,17'h00000,1'b1,1'b0,17'h00000,4'd0,4'b0000,3'd0,1'b1,1'b0));
      vt.push_back(mk(1'b0,1'b0,4'd0,17'h00000,1'b1,1'b0,17'h00000,4'd0,4'b0000,3'd0,1'b1,1'b0));
      vt.push_back(mk(1'b0,1'b1,4'd3,17'h18000,1'b0,1'b1,17'h18000,4'd3,4'b0010,3'd1,1'b1,1'b0));
      vt.push_back(mk(1'b0,1'b1,4'd5,17'h00000,1'b1,1'b1,17'h00000,4'd5,4'b1001,3'd1,1'b1,1'b0));
      vt.push_back(mk(1'b0,1'b0,4'd0,17'h00000,1'b1,1'b0,17'h00000,4'd0,4'b0000,3'd0,1'b1,1'b0));
      // fill to DEPTH with consumer stalled, then overflow attempt
      vt.push_back(mk(1'b0,1'b1,4'd0,17'h00001,1'b0,1'b1,17'h00001,4'd0,4'b0000,3'd1,1'b1,1'b0));
      vt.push_back(mk(1'b0,1'b1,4'd0,17'h00002,1'b0,1'b1,17'h00001,4'd0,4'b0000,3'd2,1'b1,1'b0));
      vt.push_back(mk(1'b0,1'b1,4'd0,17'h00003,1'b0,1'b1,17'h00001,4'd0,4'b0000,3'd3,1'b1,1'b0));
      vt.push_back(mk(1'b0,1'b1,4'd0,17'h00004,1'b0,1'b1,17'h00001,4'd0,4'b0000,3'd4,1'b0,1'b0));
      vt.push_back(mk(1'b0,1'b1,4'd0,17'h00005,1'b0,1'b1,17'h00001,4'd0,4'b0000,3'd4,1'b0,1'b1));
      vt.push_back(mk(1'b0,1'b0,4'd0,17'h00000,1'b1,1'b1,17'h00002,4'd0,4'b0000,3'd3,1'b1,1'b1));
      vt.push_back(mk(1'b0,1'b0,4'd0,17'h00000,1'b1,1'b1,17'h00003,4'd0,4'b0000,3'd2,1'b1,1'b1));
      vt.push_back(mk(1'b0,1'b0,4'd0,17'h00000,1'b1,1'b1,17'h00004,4'd0,4'b0000,3'd1,1'b1,1'b1));
      vt.push_back(mk(1'b0,1'b0,4'd0,17'h00000,1'b1,1'b0,17'h00000,4'd0,4'b0000,3'd0,1'b1,1'b1));
      // simultaneous push/pop at count 2, then push+pop at empty
      vt.push_back(mk(1'b0,1'b1,4'd1,17'h00006,1'b0,1'b1,17'h00006,4'd1,4'b0000,3'd1,1'b1,1'b1));
      vt.push_back(mk(1'b0,1'b1,4'd1,17'h00007,1'b0,1'b1,17'h00006,4'd1,4'b0000,3'd2,1'b1,1'b1));
      vt.push_back(mk(1'b0,1'b1,4'd1,17'h00008,1'b1,1'b1,17'h00007,4'd1,4'b0000,3'd2,1'b1,1'b1));
      vt.push_back(mk(1'b0,1'b0,4'd0,17'h00000,1'b1,1'b1,17'h00008,4'd1,4'b0000,3'd1,1'b1,1'b1));
      vt.push_back(mk(1'b0,1'b0,4'd0,17'h00000,1'b1,1'b0,17'h00000,4'd0,4'b0000,3'd0,1'b1,1'b1));
      vt.push_back(mk(1'b0,1'b1,4'd0,17'h00009,1'b1,1'b1,17'h00009,4'd0,4'b0000,3'd1,1'b1,1'b1));
      // reset with three entries held, then first push lands at the head
      vt.push_back(mk(1'b0,1'b1,4'd0,17'h0000A,1'b0,1'b1,17'h00009,4'd0,4'b0000,3'd2,1'b1,1'b1));
      vt.push_back(mk(1'b0,1'b1,4'd0,17'h0000B,1'b0,1'b1,17'h00009,4'd0,4'b0000,3'd3,1'b1,1'b1));
      vt.push_back(mk(1'b1,1'b1,4'd0,17'h0000C,1'b0,1'b0,17'h00000,4'd0,4'b0000,3'd0,1'b1,1'b0));
      vt.push_back(mk(1'b0,1'b1,4'd1,17'h000AB,1'b0,1'b1,17'h000AB,4'd1,4'b0000,3'd1,1'b1,1'b0));
      vt.push_back(mk(1'b0,1'b0,4'd0,17'h00000,1'b1,1'b0,17'h00000,4'd0,4'b0000,3'd0,1'b1,1'b0));
      // add with no carry-out but sign bit set
      vt.push_back(mk(1'b0,1'b1,4'd2,17'h0FFFF,1'b0,1'b1,17'h0FFFF,4'd2,4'b0010,3'd1,1'b1,1'b0));
      vt.push_back(mk(1'b0,1'b0,4'd0,17'h00000,1'b1,1'b0,17'h00000,4'd0,4'b0000,3'd0,1'b1,1'b0));

      @(negedge clk);
      for (int i = 0; i < vt.size(); i++) begin
         cycle(vt[i].rst, vt[i].iv, vt[i].op, vt[i].y, vt[i].ordy);
         check_all($sformatf("vec%0d", i), vt[i].ev, vt[i].ey, vt[i].eop, vt[i].ef,
                   vt[i].ecnt, vt[i].erdy, vt[i].eovf);
      end

      // Wrap-around: streaming consumer keeps occupancy at one entry.
      for (int i = 0; i < 10; i++) begin
         cycle(1'b0, 1'b1, 4'd0, 17'(i), 1'b1);
         check_all($sformatf("wrap%0d", i), 1'b1, 17'(i), 4'd0,
                   (i == 0) ? 4'b1000 : 4'b0000, 3'd1, 1'b1, 1'b0);
      end
      cycle(1'b0, 1'b0, 4'd0, 17'h0, 1'b1);
      check_all("wrap_drain", 1'b0, 17'h0, 4'd0, 4'b0000, 3'd0, 1'b1, 1'b0);

      // Randomized traffic against the queue model.
      cycle(1'b1, 1'b0, 4'd0, 17'h0, 1'b0);
      q.delete();
      movf = 1'b0;
      for (int i = 0; i < 600; i++) begin
         logic        r, iv, ordy;
         logic [3:0]  op;
         logic [16:0] y;
         r    = ($urandom_range(0, 79) == 0);
         iv   = ($urandom_range(0, 3) != 0);
         ordy = ($urandom_range(0, 2) != 0);
         op   = 4'($urandom_range(0, 15));
         y    = 17'($urandom_range(0, 17'h1FFFF));
         if ($urandom_range(0, 7) == 0) y[15:0] = 16'h0000;
         if (r) begin
            q.delete();
            movf = 1'b0;
         end else begin
            bit full, do_push, do_pop;
            ent_t e;
            full    = (q.size() == 4);
            do_push = iv && !full;
            do_pop  = ordy && (q.size() > 0);
            if (iv && full) movf = 1'b1;
            if (do_pop) void'(q.pop_front());
            if (do_push) begin
               e.y = y;
               e.op = op;
               q.push_back(e);
            end
         end
         cycle(r, iv, op, y, ordy);
         model_expect($sformatf("rnd%0d", i));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/alu_result_fifo.md
# alu_result_fifo

Downstream stage of the 16-bit ALU: captures each 17-bit ALU result together with the 4-bit operation select that produced it. It derives status flags (zero, carry, negative, illegal-op) and buffers the tagged results in a small FIFO with valid/ready handshakes on both sides. Results can then be drained by a register-file writeback or a test monitor at its own pace.

## Interface

Parameters:
- DEPTH, 4, number of entries; power of two, minimum 2.
- AW, $clog2(DEPTH), pointer width (derived, not overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  producer has a result on in_y/in_op this cycle.
- in_ready  output  1  FIFO accepts a push this cycle.
- in_op  input  4  ALU select that produced in_y.
- in_y  input  17  ALU result; bit 16 is the carry-out of the add.
- out_valid  output  1  head entry is presented on out_*.
- out_ready  input  1  consumer takes the head entry this cycle.
- out_y  output  17  head result.
- out_op  output  4  head operation select.
- out_z  output  1  head zero flag.
- out_c  output  1  head carry flag.
- out_n  output  1  head negative flag.
- out_ill  output  1  head illegal-op flag.
- count  output  AW+1  number of occupied entries, 0..DEPTH.
- ovf  output  1  sticky: push attempted while full.

## Operation

- Push occurs when in_valid && in_ready. Pop occurs when out_valid && out_ready.
- in_ready = (count != DEPTH). It depends only on state, never on out_ready, so there is no combinational in-to-out path.
- Flags are computed at push time from in_y/in_op and stored with the entry:
  - z = (in_y[15:0] == 0). Bit 16 is excluded.
  - c = in_y[16] when in_op == 2, otherwise 0.
  - n = in_y[15].
  - ill = (in_op > 3). The entry is still stored; ill does not block the push.
- Storage is a circular buffer with write pointer wp and read pointer rp, each AW bits. Both wrap from DEPTH-1 to 0. count tracks occupancy; pointers alone are not used to distinguish full from empty.
- Simultaneous push and pop when 0 < count < DEPTH: both pointers advance and count is unchanged.
- Push and pop in the same cycle when count == 0: only the push happens, because out_valid is 0.
- Push while full: no push is possible since in_ready = 0. If in_valid is 1 while count == DEPTH, ovf sets and stays set until rst. Entry contents are unaffected.
- Pop while empty: ignored. Pointers and count are unchanged.
- out_valid = (count != 0).
- out_y, out_op, out_z, out_c, out_n and out_ill show the entry at rp when out_valid = 1. All of them are forced to 0 when out_valid = 0.
- Reset while entries are held: all entries are discarded. wp = rp = 0, count = 0, ovf = 0. The first push after reset lands in slot 0.

## Timing

- Reset values, in the cycle after rst is sampled high: in_ready = 1, out_valid = 0, count = 0, ovf = 0, and out_y, out_op and all flags = 0. Storage contents are don't-care and are masked.
- Latency: a push sampled at edge k makes out_valid = 1 with that entry's data visible after edge k, i.e. in cycle k+1. There is no same-cycle fall-through.
- A pop sampled at edge k presents the next entry, or out_valid = 0, after edge k.
- Throughput: one push and one pop per cycle sustained.
- count and in_ready update on the same edge as the push or pop that changes them.
- The consumer may hold out_ready low indefinitely. out_* stay stable while out_valid = 1 and no pop occurs.

## Test plan

- Reset then single push: in_op = 2, in_y = 17'h10000 -> one cycle later out_valid = 1, out_y = 17'h10000, out_z = 1, out_c = 1, out_n = 0, out_ill = 0, count = 1.
- Flag masking: push in_op = 3, in_y = 17'h18000 -> out_c = 0, out_n = 1, out_z = 0. Push in_op = 5, in_y = 0 -> out_ill = 1, out_z = 1.
- Fill and overflow with DEPTH = 4: push 1, 2, 3, 4 with out_ready = 0 -> count = 4, in_ready = 0. Hold in_valid one more cycle -> ovf = 1, and draining then yields exactly 1, 2, 3, 4 in order.
- Wrap-around: 10 pushes of values 0..9 with out_ready = 1 continuously -> output order is 0..9, count never exceeds 1 after the initial fill, and ovf stays 0.
- Simultaneous push/pop at count = 2 -> count stays 2 and head order is preserved. Pop attempted at count = 0 -> count stays 0 and out_* stay 0.
- Reset mid-operation with count = 3 -> next cycle count = 0, out_valid = 0, ovf = 0. A subsequent push of 17'h00AB appears as the head one cycle later.
